// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters.
// Grants up to two requests per cycle (port A, port B) and routes read data back.
module dpram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr_a,
  output logic [ADDR_WIDTH-1:0]         ram_addr_b,
  output logic [DATA_WIDTH-1:0]         ram_data_a,
  output logic [DATA_WIDTH-1:0]         ram_data_b,
  output logic                          ram_we_a,
  output logic                          ram_we_b,
  input  logic [DATA_WIDTH-1:0]         ram_q_a,
  input  logic [DATA_WIDTH-1:0]         ram_q_b
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Cyclic index arithmetic; works for non-power-of-two requester counts.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
    int sum;
    sum = 32'(base) + off;
    return (sum >= NUM_REQ) ? PW'(sum - NUM_REQ) : PW'(sum);
  endfunction

  logic [PW-1:0]                 r_ptr;
  logic [PW-1:0]                 r_own_a;
  logic [PW-1:0]                 r_own_b;
  logic                          r_rd_a;
  logic                          r_rd_b;
  logic [NUM_REQ-1:0]            r_rvalid;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rdata;

  logic [PW-1:0]         w_a_idx;
  logic [PW-1:0]         w_b_idx;
  logic                  w_a_found;
  logic                  w_b_found;
  logic                  w_collide;
  logic                  w_a_gnt;
  logic                  w_b_gnt;
  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [DATA_WIDTH-1:0] w_wdata_a;
  logic [DATA_WIDTH-1:0] w_wdata_b;
  logic                  w_we_a;
  logic                  w_we_b;

  // First two requesters in cyclic order starting at r_ptr.
  always_comb begin
    w_a_found = 1'b0;
    w_b_found = 1'b0;
    w_a_idx   = '0;
    w_b_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[wrap_inc(r_ptr, k)] && !w_a_found) begin
        w_a_found = 1'b1;
        w_a_idx   = wrap_inc(r_ptr, k);
      end else if (req[wrap_inc(r_ptr, k)] && !w_b_found) begin
        w_b_found = 1'b1;
        w_b_idx   = wrap_inc(r_ptr, k);
      end else begin
      end
    end
  end

  // Collision check, grants and RAM pin drive; idle ports are forced to zero.
  always_comb begin
    w_addr_a  = req_addr[32'(w_a_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_addr_b  = req_addr[32'(w_b_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_wdata_a = req_wdata[32'(w_a_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_wdata_b = req_wdata[32'(w_b_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_we_a    = req_we[w_a_idx];
    w_we_b    = req_we[w_b_idx];
    w_collide = w_b_found && (w_addr_a == w_addr_b) && (w_we_a || w_we_b);
    w_a_gnt   = w_a_found && !rst;
    w_b_gnt   = w_b_found && !w_collide && !rst;
    gnt = '0;
    if (w_a_gnt) gnt[w_a_idx] = 1'b1;
    else         gnt = gnt;
    if (w_b_gnt) gnt[w_b_idx] = 1'b1;
    else         gnt = gnt;
    ram_addr_a = w_a_gnt ? w_addr_a  : '0;
    ram_data_a = w_a_gnt ? w_wdata_a : '0;
    ram_we_a   = w_a_gnt && w_we_a;
    ram_addr_b = w_b_gnt ? w_addr_b  : '0;
    ram_data_b = w_b_gnt ? w_wdata_b : '0;
    ram_we_b   = w_b_gnt && w_we_b;
  end

  // Pointer moves past the last granted index so a deferred port-B loser wins next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ptr <= '0;
    else if (w_b_gnt) r_ptr <= wrap_inc(w_b_idx, 32'd1);
    else if (w_a_gnt) r_ptr <= wrap_inc(w_a_idx, 32'd1);
    else              r_ptr <= r_ptr;
  end

  // Remember which requester owns each in-flight RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_a  <= 1'b0;
      r_rd_b  <= 1'b0;
      r_own_a <= '0;
      r_own_b <= '0;
    end else begin
      r_rd_a  <= w_a_gnt && !w_we_a;
      r_rd_b  <= w_b_gnt && !w_we_b;
      r_own_a <= w_a_idx;
      r_own_b <= w_b_idx;
    end
  end

  // Route registered RAM outputs back to their owners as one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_rd_a) begin
        r_rvalid[r_own_a] <= 1'b1;
        r_rdata[32'(r_own_a)*DATA_WIDTH +: DATA_WIDTH] <= ram_q_a;
      end else begin
      end
      if (r_rd_b) begin
        r_rvalid[r_own_b] <= 1'b1;
        r_rdata[32'(r_own_b)*DATA_WIDTH +: DATA_WIDTH] <= ram_q_b;
      end else begin
      end
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Self-checking bench for dpram_arbiter: behavioural RAM plus a transaction-level
// reference model (scan-order queue, memory array, pending-return table).
module tb_dpram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rvalid;
  logic [NR*DW-1:0] rdata;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [DW-1:0]    ram_data_a, ram_data_b;
  logic             ram_we_a, ram_we_b;
  logic [DW-1:0]    ram_q_a, ram_q_b;

  always #5 clk = ~clk;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // Dual-port RAM with registered read; output holds during a write.
  logic [DW-1:0] ram [2**AW] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
    else          ram_q_a <= ram[ram_addr_a];
    if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    else          ram_q_b <= ram[ram_addr_b];
  end

  // Reference model state
  logic [DW-1:0] m_mem [2**AW] = '{default: '0};
  int            m_ptr;
  logic [NR-1:0] m_rv;
  logic [DW-1:0] m_rdata [NR];
  logic [NR-1:0] pend;
  logic [DW-1:0] pend_d [NR];
  int            e_a, e_b;

  // Requester-side transaction state
  logic [NR-1:0] p_valid, p_we;
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_data [NR];
  int            mode;
  int            gcnt [NR];
  int            n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i]                = p_valid[i];
      req_we[i]             = p_we[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_we[i]    = we;
    p_addr[i]  = a;
    p_data[i]  = d;
  endtask

  // Expected winners: first two requesters in cyclic order from m_ptr,
  // with the second dropped on a same-address conflict involving a write.
  task automatic predict();
    int q[$];
    e_a = -1;
    e_b = -1;
    for (int k = 0; k < NR; k++)
      if (!rst && p_valid[(m_ptr + k) % NR]) q.push_back((m_ptr + k) % NR);
    if (q.size() > 0) e_a = q[0];
    if (q.size() > 1) e_b = q[1];
    if (e_b >= 0 && p_addr[e_a] == p_addr[e_b] && (p_we[e_a] || p_we[e_b])) e_b = -1;
  endtask

  task automatic update();
    int ws [2];
    if (rst) begin
      m_ptr = 0;
      m_rv  = '0;
      pend  = '0;
      for (int i = 0; i < NR; i++) m_rdata[i] = '0;
    end else begin
      m_rv = pend;
      for (int i = 0; i < NR; i++) if (pend[i]) m_rdata[i] = pend_d[i];
      pend = '0;
      ws[0] = e_a;
      ws[1] = e_b;
      for (int j = 0; j < 2; j++)
        if (ws[j] >= 0 && !p_we[ws[j]]) begin
          pend[ws[j]]   = 1'b1;
          pend_d[ws[j]] = m_mem[p_addr[ws[j]]];
        end
      for (int j = 0; j < 2; j++)
        if (ws[j] >= 0) begin
          if (p_we[ws[j]]) m_mem[p_addr[ws[j]]] = p_data[ws[j]];
          p_valid[ws[j]] = 1'b0;
        end
      if (e_b >= 0)      m_ptr = (e_b + 1) % NR;
      else if (e_a >= 0) m_ptr = (e_a + 1) % NR;
    end
  endtask

  task automatic gen();
    for (int i = 0; i < NR; i++)
      if (!p_valid[i]) begin
        if (mode == 1 && $urandom_range(0, 99) < 60) begin
          p_valid[i] = 1'b1;
          p_we[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = ($urandom_range(0, 9) == 0) ? 6'd63 : AW'($urandom_range(0, 7));
          p_data[i]  = DW'($urandom);
        end else if (mode == 2) begin
          set_req(i, 1'b0, AW'(i), 8'h00);
        end
      end
  endtask

  task automatic step(input bit rst_mid);
    logic [NR-1:0]    eg;
    logic [NR*DW-1:0] erd;
    logic [AW+DW:0]   pa, pb;
    @(negedge clk);
    predict();
    eg = '0;
    pa = '0;
    pb = '0;
    if (e_a >= 0) begin eg[e_a] = 1'b1; pa = {p_we[e_a], p_addr[e_a], p_data[e_a]}; end
    if (e_b >= 0) begin eg[e_b] = 1'b1; pb = {p_we[e_b], p_addr[e_b], p_data[e_b]}; end
    for (int i = 0; i < NR; i++) erd[i*DW +: DW] = m_rdata[i];
    chk("gnt", gnt, eg);
    chk("port_a", {ram_we_a, ram_addr_a, ram_data_a}, pa);
    chk("port_b", {ram_we_b, ram_addr_b, ram_data_b}, pb);
    chk("rvalid", rvalid, m_rv);
    chk("rdata", rdata, erd);
    for (int i = 0; i < NR; i++) gcnt[i] += int'(gnt[i]);
    if (rst_mid) begin
      rst     = 1'b1;
      p_valid = '0;
      drive();
    end
    @(posedge clk);
    update();
    #1;
    gen();
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (|p_valid && n < 50) begin
      step(1'b0);
      n++;
    end
    chk("drain_timeout", 64'(|p_valid), 64'd0);
    repeat (3) step(1'b0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    mode    = 0;
    m_ptr   = 0;
    m_rv    = '0;
    pend    = '0;
    p_valid = '0;
    p_we    = '0;
    for (int i = 0; i < NR; i++) begin
      m_rdata[i] = '0;
      pend_d[i]  = '0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
      gcnt[i]    = 0;
    end
    drive();

    // Reset with a pending write: no grant, no RAM write while rst is high.
    #1 rst = 1'b1;
    set_req(2, 1'b1, 6'd3, 8'h11);
    drive();
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);

    // Single write then read of address 5.
    set_req(0, 1'b1, 6'd5, 8'hA5); drive(); step(1'b0);
    set_req(0, 1'b0, 6'd5, 8'h00); drive();
    repeat (3) step(1'b0);
    chk("rd0_a5", 64'(rdata[7:0]), 64'hA5);

    // Preload addresses 20..23.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(20 + i), DW'(8'h40 + i));
    drive();
    drain();

    // Reset asserted with a granted read in flight; the return must be dropped.
    set_req(1, 1'b0, 6'd7, 8'h00); drive();
    step(1'b1);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    step(1'b0);

    // Dual grant from ptr 0, all reads.
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(20 + i), 8'h00);
    drive();
    repeat (4) step(1'b0);
    chk("dual_rdata", 64'(rdata), 64'h43424140);

    // Write/read collision on address 10.
    set_req(0, 1'b1, 6'd10, 8'h3C);
    set_req(2, 1'b0, 6'd10, 8'h00);
    drive();
    repeat (4) step(1'b0);
    chk("coll_rdata2", 64'(rdata[23:16]), 64'h3C);

    // Two reads of the same address are granted together.
    set_req(0, 1'b1, 6'd63, 8'hFF); drive(); step(1'b0);
    set_req(1, 1'b0, 6'd63, 8'h00);
    set_req(3, 1'b0, 6'd63, 8'h00);
    drive();
    repeat (3) step(1'b0);
    chk("rr_rdata1", 64'(rdata[15:8]), 64'hFF);
    chk("rr_rdata3", 64'(rdata[31:24]), 64'hFF);

    // Fairness under continuous load.
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    mode = 2;
    gen();
    drive();
    repeat (8) step(1'b0);
    mode = 0;
    for (int i = 0; i < NR; i++) chk("fair", 64'(gcnt[i]), 64'd4);
    drain();

    // Randomized traffic.
    mode = 1;
    repeat (400) step(1'b0);
    mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Shares one dual-port RAM (2 synchronous ports, registered read, no read-during-write output update) among NUM_REQ requesters.
- Each cycle, round-robin arbitration grants up to two requests, one per RAM port.
- Drives the RAM port pins, resolves same-address port collisions, and routes registered read data back to the originating requester.
- Sits between client blocks and the RAM instance.

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 6, RAM address width
- NUM_REQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  request valid per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat, same packing
- gnt  out  NUM_REQ  combinational grant; request accepted at the clk edge where req&gnt
- rvalid  out  NUM_REQ  registered one-cycle read-return pulse
- rdata  out  NUM_REQ*DATA_WIDTH  read data per requester, valid when rvalid[i]
- ram_addr_a, ram_addr_b  out  ADDR_WIDTH  to RAM addr ports
- ram_data_a, ram_data_b  out  DATA_WIDTH  to RAM write-data ports
- ram_we_a, ram_we_b  out  1  to RAM write enables
- ram_q_a, ram_q_b  in  DATA_WIDTH  RAM registered read outputs

Behaviour:
- Reset (async, immediate):
  - ptr = 0; rvalid = 0; rdata = 0; pending-return regs cleared.
  - While rst = 1: gnt = 0 and ram_we_a/b = 0.
  - A read in flight when rst asserts is dropped; no rvalid after release.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - gnt depends on the current req and registered ptr only; no combinational path from ram_q.
- Arbitration, combinational per cycle:
  - Winner A = first i with req[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ; it drives port A.
  - Winner B = next requesting index after A, same cyclic scan; it drives port B.
  - At most one grant per requester per cycle. No requests -> no grants.
- Collision rule:
  - If A and B have equal addresses and either is a write, B is not granted that cycle and port B idles (ram_we_b = 0).
  - B retries next cycle and wins, because ptr moves past A.
  - Two reads to the same address are both granted.
- Pointer update at the edge:
  - If any grant, ptr <= (highest-order granted index in scan order) + 1 mod NUM_REQ.
  - Otherwise ptr holds.
- RAM drive:
  - Idle port: addr = 0, data = 0, we = 0.
  - Granted port: addr/data/we from its winner.
  - A granted write commits at that edge; no rvalid for writes.
- Read return:
  - At the grant edge, register port-owner index plus a read flag for each port.
  - Next cycle, ram_q_a/q_b are routed: rdata[owner] <= q and rvalid[owner] <= 1 for exactly one cycle.
  - Read latency: gnt at edge N -> rvalid high during cycle N+1 -> rdata valid through cycle N+1, held until overwritten.
- Back-to-back:
  - A requester may re-request immediately after gnt.
  - Returns pipeline at one per cycle per port.
- Write-then-read, same address, in consecutive cycles returns the new data (RAM write completes first).

Test Plan:
- Reset: assert rst mid-read (req[1] read granted, rst before the next edge) -> rvalid stays 0 through and after release; ptr = 0; ram_we_a/b = 0 during rst.
- Single write/read: req[0] write addr 5 data 8'hA5, then read addr 5 -> gnt[0] each cycle; port A used; rvalid[0] one cycle after the read grant, rdata[0] = 8'hA5.
- Dual grant: req = 4'b1111, all reads, distinct addrs, ptr = 0 -> cycle 1 grants 0 (A), 1 (B); cycle 2 grants 2, 3; rvalid pairs arrive a cycle later with correct per-requester data.
- Collision: req[0] write addr 10 data 8'h3C, req[2] read addr 10, ptr = 0 -> cycle 1 gnt = 4'b0001, ram_we_b = 0; cycle 2 gnt[2] = 1; rdata[2] = 8'h3C.
- Fairness: req = 4'b1111 held 8 cycles -> each requester granted exactly 4 times; no requester starves.
- Read-read same address: req[1], req[3] read addr 63 holding 8'hFF -> both granted the same cycle; rvalid[1] = rvalid[3] = 1 next cycle, both rdata = 8'hFF.
